fetch_stage: RTL and testbench

- Pipelined instruction-fetch stage for the MIPS pipeline: owns the PC register and the IF/ID pipeline register.
- Computes redirect targets (branch, jump, jump-register) resolved by a later stage.
- Provides stall hold, redirect flush, a misaligned-target trap and saturating performance counters.
- Sits between the instruction memory and the decode stage.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect target selection, IF/ID pipeline
// register, misaligned-target trap and saturating redirect/stall counters.
module fetch_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC    = 32'h0000_0080,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  input  logic                  jumpr_i,
  input  logic [ADDR_WIDTH-1:0] ex_pc_plus4_i,
  input  logic [31:0]           ex_imm_i,
  input  logic [25:0]           jump_index_i,
  input  logic [ADDR_WIDTH-1:0] jr_addr_i,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic [31:0]           instr_i,
  output logic                  id_valid_o,
  output logic [31:0]           id_instr_o,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4_o,
  output logic                  trap_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] PcStep   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ResetPc  = RESET_PC[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] TrapPc   = TRAP_PC[ADDR_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0]  CntOne   = CNT_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  id_valid_q, id_valid_d;
  logic [31:0]           id_instr_q, id_instr_d;
  logic [ADDR_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic                  trap_q, trap_d;
  logic [CNT_WIDTH-1:0]  redirect_cnt_q, redirect_cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [31:0]           imm_shifted;
  logic [ADDR_WIDTH-1:0] branch_tgt;
  logic [ADDR_WIDTH-1:0] jump_tgt;
  logic [ADDR_WIDTH-1:0] target;
  logic                  redirect;

  assign pc_plus4    = pc_q + PcStep;
  assign imm_shifted = {ex_imm_i[29:0], 2'b00};
  assign branch_tgt  = ex_pc_plus4_i + imm_shifted[ADDR_WIDTH-1:0];

  // At the minimum width the jump index fills the whole address.
  if (ADDR_WIDTH > 28) begin : g_jump_upper
    assign jump_tgt = {ex_pc_plus4_i[ADDR_WIDTH-1:28], jump_index_i, 2'b00};
  end else begin : g_jump_full
    assign jump_tgt = {jump_index_i, 2'b00};
  end

  assign redirect = jumpr_i | jump_i | branch_taken_i;

  always_comb begin
    target = branch_tgt;
    if (jumpr_i) begin
      target = jr_addr_i;
    end else if (jump_i) begin
      target = jump_tgt;
    end
  end

  always_comb begin
    pc_d           = pc_plus4;
    trap_d         = 1'b0;
    id_valid_d     = 1'b1;
    id_instr_d     = instr_i;
    id_pc_plus4_d  = pc_plus4;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;

    if (redirect) begin
      // Redirect beats stall: the wrong-path fetch in IF/ID is squashed to a NOP.
      if (target[1:0] != 2'b00) begin
        pc_d   = TrapPc;
        trap_d = 1'b1;
      end else begin
        pc_d = target;
      end
      id_valid_d    = 1'b0;
      id_instr_d    = 32'h0;
      id_pc_plus4_d = '0;
    end else if (stall_i) begin
      pc_d          = pc_q;
      id_valid_d    = id_valid_q;
      id_instr_d    = id_instr_q;
      id_pc_plus4_d = id_pc_plus4_q;
    end

    if (redirect && (redirect_cnt_q != '1)) begin
      redirect_cnt_d = redirect_cnt_q + CntOne;
    end
    if (stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q           <= ResetPc;
      id_valid_q     <= 1'b0;
      id_instr_q     <= 32'h0;
      id_pc_plus4_q  <= '0;
      trap_q         <= 1'b0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      pc_q           <= pc_d;
      id_valid_q     <= id_valid_d;
      id_instr_q     <= id_instr_d;
      id_pc_plus4_q  <= id_pc_plus4_d;
      trap_q         <= trap_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign instr_addr_o   = pc_q;
  assign id_valid_o     = id_valid_q;
  assign id_instr_o     = id_instr_q;
  assign id_pc_plus4_o  = id_pc_plus4_q;
  assign trap_o         = trap_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default instance plus a 2-bit-counter instance
// sharing the same control inputs; memory returns the fetch address as the instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, jumpr;
  logic [31:0] ex_pc_plus4, ex_imm, jr_addr;
  logic [25:0] jump_index;

  logic [31:0] instr_addr, id_instr, id_pc_plus4;
  logic        id_valid, trap;
  logic [15:0] redirect_cnt, stall_cnt;

  logic [31:0] s_instr_addr, s_id_instr, s_id_pc_plus4;
  logic        s_id_valid, s_trap;
  logic [1:0]  s_redirect_cnt, s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .jumpr_i        (jumpr),
    .ex_pc_plus4_i  (ex_pc_plus4),
    .ex_imm_i       (ex_imm),
    .jump_index_i   (jump_index),
    .jr_addr_i      (jr_addr),
    .instr_addr_o   (instr_addr),
    .instr_i        (instr_addr),
    .id_valid_o     (id_valid),
    .id_instr_o     (id_instr),
    .id_pc_plus4_o  (id_pc_plus4),
    .trap_o         (trap),
    .redirect_cnt_o (redirect_cnt),
    .stall_cnt_o    (stall_cnt)
  );

  fetch_stage #(.CNT_WIDTH(2)) u_small (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .jumpr_i        (jumpr),
    .ex_pc_plus4_i  (ex_pc_plus4),
    .ex_imm_i       (ex_imm),
    .jump_index_i   (jump_index),
    .jr_addr_i      (jr_addr),
    .instr_addr_o   (s_instr_addr),
    .instr_i        (s_instr_addr),
    .id_valid_o     (s_id_valid),
    .id_instr_o     (s_id_instr),
    .id_pc_plus4_o  (s_id_pc_plus4),
    .trap_o         (s_trap),
    .redirect_cnt_o (s_redirect_cnt),
    .stall_cnt_o    (s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; branch_taken = 0; jump = 0; jumpr = 0;
  endtask

  initial begin
    rst = 1; clear_ctl();
    ex_pc_plus4 = 0; ex_imm = 0; jr_addr = 0; jump_index = 0;
    step(); step();
    check_eq("rst_addr", instr_addr, 32'h0);
    check_eq("rst_valid", {31'b0, id_valid}, 32'h0);
    check_eq("rst_instr", id_instr, 32'h0);
    check_eq("rst_trap", {31'b0, trap}, 32'h0);
    check_eq("rst_rcnt", {16'b0, redirect_cnt}, 32'h0);
    check_eq("rst_scnt", {16'b0, stall_cnt}, 32'h0);

    // Free-running fetch
    rst = 0;
    check_eq("run0_addr", instr_addr, 32'h0);
    step();
    check_eq("run1_addr", instr_addr, 32'h4);
    check_eq("run1_valid", {31'b0, id_valid}, 32'h1);
    check_eq("run1_instr", id_instr, 32'h0);
    check_eq("run1_pc4", id_pc_plus4, 32'h4);
    step();
    check_eq("run2_addr", instr_addr, 32'h8);
    check_eq("run2_instr", id_instr, 32'h4);
    check_eq("run2_pc4", id_pc_plus4, 32'h8);

    // Backward branch
    branch_taken = 1; ex_pc_plus4 = 32'h100; ex_imm = 32'hFFFF_FFFE;
    step();
    check_eq("br_addr", instr_addr, 32'hF8);
    check_eq("br_valid", {31'b0, id_valid}, 32'h0);
    check_eq("br_instr", id_instr, 32'h0);
    check_eq("br_rcnt", {16'b0, redirect_cnt}, 32'h1);

    // Jump beats branch, jumpr beats jump
    jump = 1; ex_pc_plus4 = 32'h3000_0010; jump_index = 26'h40;
    step();
    check_eq("j_addr", instr_addr, 32'h3000_0100);
    check_eq("j_rcnt", {16'b0, redirect_cnt}, 32'h2);
    branch_taken = 0; jumpr = 1; jr_addr = 32'h400;
    step();
    check_eq("jr_addr", instr_addr, 32'h400);
    check_eq("jr_rcnt", {16'b0, redirect_cnt}, 32'h3);
    clear_ctl();
    step();
    check_eq("post_jr_addr", instr_addr, 32'h404);
    check_eq("post_jr_valid", {31'b0, id_valid}, 32'h1);
    check_eq("post_jr_instr", id_instr, 32'h400);

    // Stall hold
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_addr", instr_addr, 32'h404);
      check_eq("stall_instr", id_instr, 32'h400);
      check_eq("stall_pc4", id_pc_plus4, 32'h404);
    end
    check_eq("stall_cnt3", {16'b0, stall_cnt}, 32'h3);

    // Redirect during stall
    jumpr = 1; jr_addr = 32'h200;
    step();
    check_eq("sjr_addr", instr_addr, 32'h200);
    check_eq("sjr_valid", {31'b0, id_valid}, 32'h0);
    check_eq("sjr_instr", id_instr, 32'h0);
    check_eq("sjr_pc4", id_pc_plus4, 32'h0);
    check_eq("sjr_scnt", {16'b0, stall_cnt}, 32'h4);
    clear_ctl();
    step();
    check_eq("post_sjr_addr", instr_addr, 32'h204);
    check_eq("post_sjr_instr", id_instr, 32'h200);

    // Misaligned JR traps
    jumpr = 1; jr_addr = 32'h202;
    step();
    check_eq("trap_addr", instr_addr, 32'h80);
    check_eq("trap_hi", {31'b0, trap}, 32'h1);
    check_eq("trap_valid", {31'b0, id_valid}, 32'h0);
    check_eq("trap_rcnt", {16'b0, redirect_cnt}, 32'h5);
    clear_ctl();
    step();
    check_eq("trap_lo", {31'b0, trap}, 32'h0);
    check_eq("post_trap_addr", instr_addr, 32'h84);
    check_eq("post_trap_instr", id_instr, 32'h80);

    // PC wrap
    jumpr = 1; jr_addr = 32'hFFFF_FFFC;
    step();
    check_eq("wrap_top", instr_addr, 32'hFFFF_FFFC);
    clear_ctl();
    step();
    check_eq("wrap_addr", instr_addr, 32'h0);
    check_eq("wrap_pc4", id_pc_plus4, 32'h0);
    check_eq("wrap_instr", id_instr, 32'hFFFF_FFFC);

    // Counter saturation on the 2-bit instance, then reset during stall
    rst = 1;
    step();
    rst = 0; stall = 1;
    check_eq("sat_start", {30'b0, s_stall_cnt}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq("sat_scnt", {30'b0, s_stall_cnt}, (i > 3) ? 32'h3 : 32'(i));
      check_eq("wide_scnt", {16'b0, stall_cnt}, 32'(i));
    end
    rst = 1;
    step();
    check_eq("rs_addr", s_instr_addr, 32'h0);
    check_eq("rs_scnt", {30'b0, s_stall_cnt}, 32'h0);
    check_eq("rs_valid", {31'b0, s_id_valid}, 32'h0);
    check_eq("rs_main_scnt", {16'b0, stall_cnt}, 32'h0);
    check_eq("rs_main_rcnt", {16'b0, redirect_cnt}, 32'h0);
    rst = 0; stall = 0;
    step();
    check_eq("rel_addr", instr_addr, 32'h4);
    check_eq("rel_instr", id_instr, 32'h0);
    check_eq("rel_valid", {31'b0, id_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
